instruction_fetch_reg: RTL and testbench

// - Fetch stage downstream of program_sequencer: takes pm_addr, samples the registered program ROM output pm_data, presents ir/ir_pc to the decoder.
// - Tracks pm_data validity across ROM latency, taken jumps (flush) and decoder stalls (one-entry skid buffer).
// - Drives seq_hold back to program_sequencer so pm_addr freezes while the decoder stalls.

---
 rtl/mpu341_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/instruction_fetch_reg.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_reg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mpu341_pkg.sv
// Shared types and constants for the mpu341 fetch stage.
package mpu341_pkg;

  localparam int IR_W_DEF   = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    FETCH_FILL = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic load;
    logic clear;
  } skid_ctl_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register (data, pc, valid) for the word in flight when the decoder stalls.
// clear has priority over load; otherwise the entry holds.
module fetch_skid_buf
  import mpu341_pkg::*;
#(
  parameter int IR_W   = IR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  skid_ctl_t         ctl,
  input  logic [IR_W-1:0]   d_data,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic              d_valid,
  output logic [IR_W-1:0]   q_data,
  output logic [ADDR_W-1:0] q_pc,
  output logic              q_valid
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_data  <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (ctl.clear) begin
      q_data  <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (ctl.load) begin
      q_data  <= d_data;
      q_pc    <= d_pc;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_reg.sv
// Fetch stage: tags registered ROM data with its address, presents ir/ir_pc, and absorbs decoder stalls.
// Optional MPU_FETCH_TRACE_EN adds fetch_count and last_jump_pc.
module instruction_fetch_reg
  import mpu341_pkg::*;
#(
  parameter int IR_W   = IR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_reset,
  input  logic [ADDR_W-1:0] pm_addr,
  input  logic [IR_W-1:0]   pm_data,
  input  logic              flush,
  input  logic              stall,
  output logic              seq_hold,
  output logic [IR_W-1:0]   ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic [3:0]        ls_nibble_ir,
  output logic [3:0]        ms_nibble_ir
`ifdef MPU_FETCH_TRACE_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [ADDR_W-1:0] last_jump_pc
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [IR_W-1:0]   ir_d;
  logic [ADDR_W-1:0] pc_d;
  logic              vld_d, hold_d;
  logic              skid_load_d, skid_clr_d;
  skid_ctl_t         skid_ctl;
  logic [IR_W-1:0]   skid_data;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_valid;

  assign ls_nibble_ir = ir[3:0];
  assign ms_nibble_ir = ir[7:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        state_q <= FETCH_FILL;
    else if (sync_reset) state_q <= FETCH_FILL;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir;
    pc_d        = ir_pc;
    vld_d       = ir_valid;
    hold_d      = seq_hold;
    skid_load_d = 1'b0;
    skid_clr_d  = 1'b0;
    if (flush) begin
      // the fall-through word in flight is squashed; target arrives after one FILL cycle
      state_d    = FETCH_FILL;
      ir_d       = IR_W'(NOP_INSTR);
      vld_d      = 1'b0;
      hold_d     = 1'b0;
      skid_clr_d = 1'b1;
    end else begin
      case (state_q)
        FETCH_FILL: begin
          vld_d   = 1'b0;
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (stall) begin
            skid_load_d = 1'b1;
            hold_d      = 1'b1;
            state_d     = FETCH_HOLD;
          end else begin
            ir_d  = pm_data;
            pc_d  = addr_q;
            vld_d = 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            ir_d       = skid_data;
            pc_d       = skid_pc;
            vld_d      = skid_valid;
            skid_clr_d = 1'b1;
            hold_d     = 1'b0;
            state_d    = FETCH_RUN;
          end
        end
        default: state_d = FETCH_FILL;
      endcase
    end
  end

  // addr_q freezes with the sequencer so it keeps tagging the replayed ROM word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      seq_hold <= 1'b0;
      addr_q   <= '0;
    end else if (sync_reset) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      seq_hold <= 1'b0;
      addr_q   <= '0;
    end else begin
      ir       <= ir_d;
      ir_pc    <= pc_d;
      ir_valid <= vld_d;
      seq_hold <= hold_d;
      if (!seq_hold) addr_q <= pm_addr;
    end
  end

  assign skid_ctl.load  = skid_load_d;
  assign skid_ctl.clear = skid_clr_d | sync_reset;

  fetch_skid_buf #(
    .IR_W   (IR_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (skid_ctl),
    .d_data  (pm_data),
    .d_pc    (addr_q),
    .d_valid (1'b1),
    .q_data  (skid_data),
    .q_pc    (skid_pc),
    .q_valid (skid_valid)
  );

`ifdef MPU_FETCH_TRACE_EN
  logic count_en;
  assign count_en = !flush && !stall &&
                    ((state_q == FETCH_RUN) || ((state_q == FETCH_HOLD) && skid_valid));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count  <= '0;
      last_jump_pc <= '0;
    end else if (sync_reset) begin
      fetch_count  <= '0;
      last_jump_pc <= '0;
    end else begin
      if (count_en) fetch_count <= fetch_count + 16'd1;
      if (flush)    last_jump_pc <= ir_pc;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_reg.sv
// Scoreboard bench: a sequencer/ROM model feeds the fetch stage; expected (ir, ir_pc) pairs are queued
// by the stimulus and popped by a monitor each time a new valid instruction is presented.
module tb_instruction_fetch_reg;

  logic       clk = 1'b0;
  logic       reset_n, sync_reset, flush, stall;
  logic [7:0] pm_addr, pm_data;
  logic       seq_hold, ir_valid;
  logic [7:0] ir, ir_pc;
  logic [3:0] ls_nibble_ir, ms_nibble_ir;
`ifdef MPU_FETCH_TRACE_EN
  logic [15:0] fetch_count;
  logic [7:0]  last_jump_pc;
`endif

  instruction_fetch_reg dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_reset   (sync_reset),
    .pm_addr      (pm_addr),
    .pm_data      (pm_data),
    .flush        (flush),
    .stall        (stall),
    .seq_hold     (seq_hold),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ls_nibble_ir (ls_nibble_ir),
    .ms_nibble_ir (ms_nibble_ir)
`ifdef MPU_FETCH_TRACE_EN
    ,
    .fetch_count  (fetch_count),
    .last_jump_pc (last_jump_pc)
`endif
  );

  always #5 clk = ~clk;

  // sequencer model: pm_addr counts, freezes on seq_hold, jumps the cycle after flush
  logic [7:0] p_prev, jmp_tgt, tgt;
  logic       jmp_pend;
  assign pm_addr = seq_hold ? p_prev : (jmp_pend ? jmp_tgt : p_prev + 8'd1);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_prev <= 8'hFF; jmp_pend <= 1'b0; jmp_tgt <= 8'h00;
    end else if (sync_reset) begin
      p_prev <= 8'hFF; jmp_pend <= 1'b0; jmp_tgt <= 8'h00;
    end else begin
      p_prev   <= pm_addr;
      jmp_pend <= flush;
      if (flush) jmp_tgt <= tgt;
    end
  end

  // registered ROM, mem[i] = i + 8'h10
  always @(posedge clk) pm_data <= pm_addr + 8'h10;

  int n_vec = 0;
  int n_err = 0;
  int loads = 0;

  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] i, input logic [7:0] pc);
    exp_t e;
    e.ir = i;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_ir(input logic [7:0] v, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = ir_valid && (ir == v);
    end
    check(name, 32'(found), 32'd1);
  endtask

  logic stall_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= 1'b0;
    else          stall_q <= stall;
  end

  // a new instruction is presented when ir is valid and was not held by a stall on the last edge
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && ir_valid && !stall_q) begin
      loads++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got ir=%0h pc=%0h, expected nothing", ir, ir_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_ir_pc", {16'h0, ir_pc, ir}, {16'h0, e.pc, e.ir});
        check("sb_nibbles", {24'h0, ms_nibble_ir, ls_nibble_ir}, {24'h0, e.ir});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; flush = 1'b0; stall = 1'b0; tgt = 8'h00;
    push(8'h10, 8'h00); push(8'h11, 8'h01); push(8'h12, 8'h02);
    push(8'h13, 8'h03); push(8'h14, 8'h04); push(8'h15, 8'h05);
    push(8'h13, 8'h03); push(8'h14, 8'h04);
    push(8'h18, 8'h08); push(8'h19, 8'h09);
    push(8'h0E, 8'hFE); push(8'h0F, 8'hFF); push(8'h10, 8'h00); push(8'h11, 8'h01);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ir", ir, 8'h00);
    check("rst_ir_pc", ir_pc, 8'h00);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_seq_hold", seq_hold, 1'b0);

    @(posedge clk); #1 reset_n = 1'b1; loads = 0;
    @(negedge clk); check("fill_c0", ir_valid, 1'b0);
    @(negedge clk); check("fill_c1", ir_valid, 1'b0);
    @(negedge clk); check("first_valid", ir_valid, 1'b1);

    // decoder stall for 3 cycles while ir=12
    wait_ir(8'h12, "wait_12");
    stall = 1'b1;
    @(negedge clk); check("stall_hold_c1", seq_hold, 1'b1); check("stall_ir_c1", ir, 8'h12);
    @(negedge clk);
    @(negedge clk); check("stall_hold_c3", seq_hold, 1'b1); check("stall_ir_c3", ir, 8'h12);
    stall = 1'b0;
    @(negedge clk); check("release_ir", ir, 8'h13); check("release_hold", seq_hold, 1'b0);

    // taken jump from ir_pc=05 to 0x03
    wait_ir(8'h15, "wait_15");
    flush = 1'b1; tgt = 8'h03;
    @(negedge clk); flush = 1'b0; check("flush_bubble0", ir_valid, 1'b0);
    @(negedge clk); check("flush_bubble1", ir_valid, 1'b0);
    @(negedge clk); check("jump_target_pc", ir_pc, 8'h03); check("jump_target_vld", ir_valid, 1'b1);

    // stall and flush in the same cycle
    wait_ir(8'h14, "wait_14");
    stall = 1'b1; flush = 1'b1; tgt = 8'h08;
    @(negedge clk);
    check("sf_seq_hold", seq_hold, 1'b0); check("sf_ir_valid", ir_valid, 1'b0);
`ifdef MPU_FETCH_TRACE_EN
    check("last_jump_pc", last_jump_pc, 8'h04);
`endif
    stall = 1'b0; flush = 1'b0;

    // flush while already holding, target 0xFE to cross the address wrap
    wait_ir(8'h19, "wait_19");
    stall = 1'b1;
    @(negedge clk); check("hold_entry", seq_hold, 1'b1);
    flush = 1'b1; tgt = 8'hFE;
    @(negedge clk);
    check("hflush_seq_hold", seq_hold, 1'b0); check("hflush_ir_valid", ir_valid, 1'b0);
    flush = 1'b0; stall = 1'b0;

    wait_ir(8'h0F, "wait_0F");
    check("wrap_pc_ff", ir_pc, 8'hFF);
    @(negedge clk); check("wrap_pc_00", ir_pc, 8'h00); check("wrap_vld", ir_valid, 1'b1);

    // async reset in HOLD
    wait_ir(8'h11, "wait_11a");
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk); check("hold_before_rst", seq_hold, 1'b1);
    push(8'h10, 8'h00); push(8'h11, 8'h01); push(8'h12, 8'h02);
    reset_n = 1'b0;
    #1;
    check("arst_ir", ir, 8'h00); check("arst_vld", ir_valid, 1'b0); check("arst_hold", seq_hold, 1'b0);
    stall = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; loads = 0;

    // sync reset in HOLD
    wait_ir(8'h12, "wait_12b");
    stall = 1'b1;
    @(negedge clk); check("hold_before_srst", seq_hold, 1'b1);
    push(8'h10, 8'h00); push(8'h11, 8'h01);
    sync_reset = 1'b1;
    #1 check("srst_not_async", seq_hold, 1'b1);
    @(negedge clk);
    check("srst_ir", ir, 8'h00); check("srst_vld", ir_valid, 1'b0); check("srst_hold", seq_hold, 1'b0);
    sync_reset = 1'b0; stall = 1'b0; loads = 0;

    wait_ir(8'h11, "wait_11b");
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef MPU_FETCH_TRACE_EN
    check("fetch_count", fetch_count, 16'(loads));
`endif
    check("sb_drain", exp_q.size(), 0);
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
